trace_capture_sched: RTL
========================

// Module: trace_capture_sched
// PURPOSE
// - Schedules capture of emulator probe channels into one shared trace-memory write port.
// - Sits beside the trace port and time manager, in the emu_clk domain.
// - Arms on request and waits for an emulation-time trigger.
// - Then decimates, snapshots enabled channels, and serialises them round-robin as [time word, ch0..chN-1] records.
// PARAMETERS
// - N_CH   8     number of probe channels
// - CH_W   25    probe channel width (fixed-point, signed)
// - DW     64    memory word width (>= max(64, CH_W))
// - DEPTH  1024  memory depth in words
// - AW     $clog2(DEPTH)  address width (derived)
// PORTS
// - emu_clk      in   1          emulation clock; all logic on rising edge
// - emu_rst_n    in   1          asynchronous, active-low reset
// - emu_time     in   64         current emulation time (from time manager)
// - dec_thr      in   24         decimation threshold; a sample is taken every dec_thr+1 cycles
// - trig_time    in   64         capture starts when emu_time >= trig_time
// - ch_en        in   N_CH       channel enable mask; latched on arm
// - arm          in   1          1-cycle pulse; starts a capture from IDLE or DONE
// - ch_data      in   N_CH*CH_W  packed channel values; ch i = [i*CH_W +: CH_W]
// - mem_valid    out  1          write request valid
// - mem_ready    in   1          memory accepts the word when mem_valid & mem_ready
// - mem_addr     out  AW         write address
// - mem_wdata    out  DW         write data
// - busy         out  1          state not IDLE/DONE
// - done         out  1          high in DONE
// - overflow     out  1          sticky: a sample event was dropped
// - n_words      out  AW+1       words written in current capture
// - stall_req    out  1          time-advance stall request (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; dec_cnt=0; latched mask=0.
// - FSM states: IDLE, ARMED, CAPTURE, WR_TIME, WR_CH, DONE.
// - IDLE/DONE + arm:
//   - latch ch_en to en_q; clear n_words, overflow, dec_cnt.
//   - go to ARMED next cycle. done drops on that edge.
// - arm in any other state is ignored.
// - ARMED: when emu_time >= trig_time (unsigned), go to CAPTURE; dec_cnt=0.
// - CAPTURE, decimation:
//   - dec_cnt increments each cycle; sample event when dec_cnt==dec_thr, then dec_cnt<=0.
//   - dec_thr=0 gives an event every cycle.
// - CAPTURE, sample event, with rec_len = 1 + popcount(en_q):
//   - if n_words + rec_len <= DEPTH: snapshot emu_time and ch_data into shadow regs, go to WR_TIME.
//   - else go to DONE; partial records are never written.
// - WR_TIME: mem_valid=1, mem_wdata=time snapshot, mem_addr=n_words.
// - WR_CH:
//   - iterate enabled channels in ascending index order, skipping disabled ones.
//   - mem_wdata = snapshot sign-extended to DW.
// - Handshake:
//   - mem_valid, mem_addr and mem_wdata stay stable until accepted.
//   - Each accept increments n_words. mem_valid never drops without an accept.
// - After the last enabled channel is accepted, return to CAPTURE.
// - en_q=0: record is the time word only; go WR_TIME -> CAPTURE.
// - Drain overlap:
//   - dec_cnt keeps running during WR_*.
//   - A sample event during WR_* is dropped and sets overflow. The record in flight is unaffected.
// - Latency: first mem_valid one cycle after the sample event. Minimum record time = rec_len cycles with mem_ready tied 1.
// - Full: exactly n_words==DEPTH reachable; then next event -> DONE; addresses never wrap.
// - Reset mid-record: abort immediately; mem_valid=0 asynchronously; no further writes.
// CONFIGURATION
// - Macro TRACE_CAPTURE_SCHED_STALL_EN.
// - Defined:
//   - stall_req=1 in WR_TIME/WR_CH, registered and asserted the same cycle mem_valid first rises.
//   - stall_req is for use as a stall dt request; dec_cnt freezes while stall_req=1.
//   - overflow therefore stays 0.
// - Undefined: stall_req tied 0; drop/overflow behaviour as above.
// TESTING
// - Basic record:
//   - Stimulus: reset, ch_en=8'h05, dec_thr=3, trig_time=0, arm, mem_ready=1.
//   - Response: records of 3 words every 4 cycles at addrs 0,1,2 / 3,4,5 (time, ch0, ch2).
//   - ch data sign-extended; ch0=-1 -> 64'hFFFF_FFFF_FFFF_FFFF.
// - Trigger:
//   - Stimulus: trig_time=1000, emu_time ramping by 10 per cycle.
//   - Response: no mem_valid before emu_time>=1000; first time word >= 1000.
// - Backpressure:
//   - Stimulus: mem_ready low 5 cycles mid-record.
//   - Response: mem_addr/mem_wdata held stable; n_words unchanged until accept.
// - Full:
//   - Stimulus: DEPTH=16, ch_en=8'h07 (rec_len=4).
//   - Response: 4 records, n_words=16, then DONE with done=1; re-arm clears n_words to 0.
// - Overflow / stall:
//   - Stimulus: dec_thr=0, ch_en=8'hFF.
//   - Response without macro: overflow=1.
//   - Response with TRACE_CAPTURE_SCHED_STALL_EN: overflow=0, stall_req high 9 cycles per record.
// - Async reset:
//   - Stimulus: emu_rst_n low during WR_CH.
//   - Response: mem_valid=0 with no clock edge; state IDLE; arm required to restart.

Source files
------------

// File: rtl/trace_capture_sched.sv
// Trace capture scheduler: trigger, decimate, snapshot, serialise [time, enabled chs] records to one write port.
// First mem_valid 1 cycle after a sample event; held stable under mem_ready backpressure. Optional TRACE_CAPTURE_SCHED_STALL_EN.
module trace_capture_sched #(
  parameter int N_CH  = 8,
  parameter int CH_W  = 25,
  parameter int DW    = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst_n,
  input  logic [63:0]          emu_time,
  input  logic [23:0]          dec_thr,
  input  logic [63:0]          trig_time,
  input  logic [N_CH-1:0]      ch_en,
  input  logic                 arm,
  input  logic [N_CH*CH_W-1:0] ch_data,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [AW:0]          n_words,
  output logic                 stall_req
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_WR_TIME, S_WR_CH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_CH-1:0]     en_q, en_d;
  logic [23:0]         dec_cnt_q, dec_cnt_d;
  logic [AW:0]         n_words_q, n_words_d;
  logic                overflow_q, overflow_d;
  logic                mem_valid_q, mem_valid_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [IW-1:0]       ch_idx_q, ch_idx_d;
  logic [N_CH*CH_W-1:0] snap_q, snap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [AW+1:0]       rec_len;
  logic                fits;
  logic                nxt_found;
  logic [IW-1:0]       nxt_idx;
  int                  start_idx;
  logic [CH_W-1:0]     sel_ch;
  logic                stall_act;
  logic                dec_run;
  logic                sample_evt;
  logic                accept;

`ifdef TRACE_CAPTURE_SCHED_STALL_EN
  logic stall_q, stall_d;
  assign stall_act = stall_q;
  assign stall_req = stall_q;
`else
  assign stall_act = 1'b0;
  assign stall_req = 1'b0;
`endif

  always_comb begin
    rec_len = (AW+2)'(1);
    for (int i = 0; i < N_CH; i++) begin
      rec_len = rec_len + (AW+2)'(en_q[i]);
    end
  end

  assign fits = ({1'b0, n_words_q} + rec_len) <= (AW+2)'(DEPTH);

  // Next enabled channel at or above start_idx; from WR_TIME the search starts at channel 0.
  always_comb begin
    start_idx = (state_q == S_WR_TIME) ? 0 : int'(ch_idx_q) + 1;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_q[i] && (i >= start_idx)) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(i);
      end
    end
  end

  assign sel_ch = snap_q[int'(nxt_idx)*CH_W +: CH_W];

  assign dec_run = ((state_q == S_CAPTURE) || (state_q == S_WR_TIME) || (state_q == S_WR_CH))
                   && !stall_act;
  assign sample_evt = dec_run && (dec_cnt_q == dec_thr);
  assign accept     = mem_valid_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    dec_cnt_d   = dec_cnt_q;
    n_words_d   = n_words_q;
    overflow_d  = overflow_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ch_idx_d    = ch_idx_q;
    snap_d      = snap_q;

    if (dec_run) begin
      dec_cnt_d = sample_evt ? '0 : dec_cnt_q + 24'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          en_d       = ch_en;
          n_words_d  = '0;
          overflow_d = 1'b0;
          dec_cnt_d  = '0;
          state_d    = S_ARMED;
        end
      end
      S_ARMED: begin
        dec_cnt_d = '0;
        if (emu_time >= trig_time) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (sample_evt) begin
          if (fits) begin
            snap_d      = ch_data;
            mem_valid_d = 1'b1;
            mem_addr_d  = n_words_q[AW-1:0];
            mem_wdata_d = DW'(emu_time);
            state_d     = S_WR_TIME;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WR_TIME, S_WR_CH: begin
        // The record in flight keeps its snapshot; a new event here is lost.
        if (sample_evt) overflow_d = 1'b1;
        if (accept) begin
          n_words_d = n_words_q + 1'b1;
          if (nxt_found) begin
            ch_idx_d    = nxt_idx;
            mem_addr_d  = mem_addr_q + 1'b1;
            mem_wdata_d = {{(DW-CH_W){sel_ch[CH_W-1]}}, sel_ch};
            state_d     = S_WR_CH;
          end else begin
            mem_valid_d = 1'b0;
            state_d     = S_CAPTURE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

`ifdef TRACE_CAPTURE_SCHED_STALL_EN
  assign stall_d = (state_d == S_WR_TIME) || (state_d == S_WR_CH);
`endif

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      dec_cnt_q   <= '0;
      n_words_q   <= '0;
      overflow_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ch_idx_q    <= '0;
      snap_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef TRACE_CAPTURE_SCHED_STALL_EN
      stall_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      dec_cnt_q   <= dec_cnt_d;
      n_words_q   <= n_words_d;
      overflow_q  <= overflow_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ch_idx_q    <= ch_idx_d;
      snap_q      <= snap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef TRACE_CAPTURE_SCHED_STALL_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign n_words   = n_words_q;

endmodule
